// File: rtl/regfile_scoreboard.sv
// Register bank with multiple read ports, write-to-read forwarding, an optional
// hardwired zero register and a per-register busy scoreboard for decode/writeback.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    claim_en,
    input  logic [ADDR_W-1:0]       claim_addr,
    output logic                    claim_ok,
    output logic [2**ADDR_W-1:0]    busy_vec
);
    localparam int NREG = 2**ADDR_W;
    localparam bit ZR   = (ZERO_REG != 0);
    localparam bit BP   = (BYPASS != 0);

    if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
        $error("regfile_scoreboard: NREAD must be in 1..4");
    end

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic              wr_ok;
    logic              claim_zero;
    logic              claim_hit;

    // A write to the zero register is dropped and must not forward or clear anything.
    assign wr_ok = wr_en && !(ZR && wr_addr == '0);

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              zero;
        logic              hit;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];
        assign zero = ZR && addr == '0;
        assign hit  = BP && wr_ok && addr == wr_addr;

        assign rd_data[k*DATA_W +: DATA_W] = zero ? '0 : (hit ? wr_data : regs_q[addr]);
        assign rd_busy[k]                  = !zero && busy_q[addr] && !hit;
    end

    assign claim_zero = ZR && claim_addr == '0;
    assign claim_hit  = BP && wr_ok && claim_addr == wr_addr;
    assign claim_ok   = claim_en && (claim_zero || !(busy_q[claim_addr] && !claim_hit));

    // Claim is applied after the release so a same-register claim ends busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (claim_ok && !claim_zero) begin
            busy_d[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: two instances (forwarding+zero reg, and neither) checked
// against a behavioural model through an expected-value queue plus directed checks.
module tb_regfile_scoreboard;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NREG = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [NR*AW-1:0] rd_addr;
    logic             claim_en;
    logic [AW-1:0]    claim_addr;

    logic [NR*DW-1:0] rd_data_a, rd_data_b;
    logic [NR-1:0]    rd_busy_a, rd_busy_b;
    logic             claim_ok_a, claim_ok_b;
    logic [NREG-1:0]  busy_vec_a, busy_vec_b;

    regfile_scoreboard dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok_a),
        .busy_vec(busy_vec_a)
    );

    regfile_scoreboard #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok_b),
        .busy_vec(busy_vec_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: index 0 = forwarding + zero register, index 1 = plain bank.
    logic [DW-1:0]   m_reg  [2][NREG];
    logic [NREG-1:0] m_busy [2];

    function automatic bit m_zr(input bit c);  return c == 1'b0; endfunction
    function automatic bit m_byp(input bit c); return c == 1'b0; endfunction

    function automatic bit m_wr_ok(input bit c);
        return wr_en && !(m_zr(c) && wr_addr == 5'd0);
    endfunction

    function automatic bit m_fwd(input bit c, input logic [AW-1:0] a);
        return m_byp(c) && m_wr_ok(c) && wr_addr == a;
    endfunction

    function automatic bit m_eff_busy(input bit c, input logic [AW-1:0] a);
        return m_busy[c][a] && !m_fwd(c, a);
    endfunction

    function automatic logic [DW-1:0] m_rd(input bit c, input logic [AW-1:0] a);
        if (m_zr(c) && a == 5'd0) return '0;
        if (m_fwd(c, a)) return wr_data;
        return m_reg[c][a];
    endfunction

    function automatic bit m_rbusy(input bit c, input logic [AW-1:0] a);
        if (m_zr(c) && a == 5'd0) return 1'b0;
        return m_eff_busy(c, a);
    endfunction

    function automatic bit m_cok(input bit c);
        if (!claim_en) return 1'b0;
        if (m_zr(c) && claim_addr == 5'd0) return 1'b1;
        return !m_eff_busy(c, claim_addr);
    endfunction

    task automatic m_reset();
        for (int c = 0; c < 2; c++) begin
            m_busy[c] = '0;
            for (int i = 0; i < NREG; i++) m_reg[c][i] = '0;
        end
    endtask

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic sb_push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_pop_chk(input logic [63:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got output %0h with no expected entry", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then check combinational outputs.
    task automatic apply(input int we, input int wa, input int wd, input int r0, input int r1,
                         input int ce, input int ca);
        logic [AW-1:0] a0, a1;
        @(negedge clk);
        wr_en      = we[0];
        wr_addr    = AW'(wa);
        wr_data    = DW'(wd);
        a0         = AW'(r0);
        a1         = AW'(r1);
        rd_addr    = {a1, a0};
        claim_en   = ce[0];
        claim_addr = AW'(ca);
        #1;
        for (int ci = 0; ci < 2; ci++) begin
            sb_push($sformatf("c%0d_rd0", ci), 64'(m_rd(1'(ci), a0)));
            sb_push($sformatf("c%0d_rd1", ci), 64'(m_rd(1'(ci), a1)));
            sb_push($sformatf("c%0d_rbusy", ci), 64'({m_rbusy(1'(ci), a1), m_rbusy(1'(ci), a0)}));
            sb_push($sformatf("c%0d_claim_ok", ci), 64'(m_cok(1'(ci))));
            sb_push($sformatf("c%0d_busy_vec", ci), 64'(m_busy[ci]));
        end
        sb_pop_chk(64'(rd_data_a[31:0]));
        sb_pop_chk(64'(rd_data_a[63:32]));
        sb_pop_chk(64'(rd_busy_a));
        sb_pop_chk(64'(claim_ok_a));
        sb_pop_chk(64'(busy_vec_a));
        sb_pop_chk(64'(rd_data_b[31:0]));
        sb_pop_chk(64'(rd_data_b[63:32]));
        sb_pop_chk(64'(rd_busy_b));
        sb_pop_chk(64'(claim_ok_b));
        sb_pop_chk(64'(busy_vec_b));
    endtask

    // Advance the model across the rising edge and check the registered scoreboard.
    task automatic tick();
        bit wok [2];
        bit cok [2];
        for (int ci = 0; ci < 2; ci++) begin
            wok[ci] = m_wr_ok(1'(ci));
            cok[ci] = m_cok(1'(ci)) && !(m_zr(1'(ci)) && claim_addr == 5'd0);
        end
        @(posedge clk);
        for (int ci = 0; ci < 2; ci++) begin
            if (wok[ci]) begin
                m_reg[ci][wr_addr]  = wr_data;
                m_busy[ci][wr_addr] = 1'b0;
            end
            if (cok[ci]) m_busy[ci][claim_addr] = 1'b1;
        end
        #1;
        chk("busy_vec_a", 64'(busy_vec_a), 64'(m_busy[0]));
        chk("busy_vec_b", 64'(busy_vec_b), 64'(m_busy[1]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        claim_en = 1'b0;
        claim_addr = '0;
        m_reset();
        #12;
        chk("por_busy_a", 64'(busy_vec_a), 64'(0));
        chk("por_busy_b", 64'(busy_vec_b), 64'(0));
        chk("por_rd_b", 64'(rd_data_b), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Preload reg5 and claim it, then hit reset between edges.
        apply(1, 5, 'h55, 5, 5, 1, 5);
        tick();
        chk("pre_busy5_a", 64'(busy_vec_a[5]), 64'(1));
        @(negedge clk);
        wr_en    = 1'b0;
        claim_en = 1'b0;
        rd_addr  = {5'd5, 5'd5};
        #1;
        chk("pre_rd5_a", 64'(rd_data_a[31:0]), 64'h55);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_rd_a", 64'(rd_data_a), 64'(0));
        chk("arst_rd_b", 64'(rd_data_b), 64'(0));
        chk("arst_busy_a", 64'(busy_vec_a), 64'(0));
        chk("arst_busy_b", 64'(busy_vec_b), 64'(0));
        chk("arst_rbusy_a", 64'(rd_busy_a), 64'(0));
        m_reset();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 1; i < 32; i++) begin
            apply(1, i, i * 10, i, i - 1, 0, 0);
            tick();
        end
        for (int i = 1; i < 31; i++) begin
            apply(0, 0, 0, i, i + 1, 0, 0);
            chk("mp_port0", 64'(rd_data_a[31:0]), 64'(i * 10));
            chk("mp_port1", 64'(rd_data_a[63:32]), 64'((i + 1) * 10));
            chk("mp_rbusy", 64'(rd_busy_a), 64'(0));
            tick();
        end

        apply(1, 0, 'hDEAD, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 1, 0, 0);
        chk("zero_rd_a", 64'(rd_data_a[31:0]), 64'(0));
        chk("plain_rd0_b", 64'(rd_data_b[31:0]), 64'hDEAD);
        tick();

        apply(1, 7, 'h1234, 1, 7, 0, 0);
        chk("bypass_a", 64'(rd_data_a[63:32]), 64'h1234);
        chk("nobypass_b", 64'(rd_data_b[63:32]), 64'd70);
        tick();
        apply(0, 0, 0, 7, 7, 0, 0);
        chk("wr7_a", 64'(rd_data_a[31:0]), 64'h1234);
        chk("wr7_b", 64'(rd_data_b[31:0]), 64'h1234);
        tick();

        apply(0, 0, 0, 3, 3, 1, 3);
        chk("claim3_ok", 64'(claim_ok_a), 64'(1));
        tick();
        chk("claim3_busy", 64'(busy_vec_a[3]), 64'(1));
        apply(0, 0, 0, 3, 3, 1, 3);
        chk("claim3_again", 64'(claim_ok_a), 64'(0));
        chk("claim3_rbusy", 64'(rd_busy_a), 64'(3));
        tick();
        apply(1, 3, 'h99, 3, 3, 0, 0);
        chk("wr3_fwd", 64'(rd_data_a[31:0]), 64'h99);
        tick();
        chk("wr3_release", 64'(busy_vec_a[3]), 64'(0));
        apply(0, 0, 0, 3, 3, 0, 0);
        chk("wr3_rd", 64'(rd_data_a[31:0]), 64'h99);
        tick();

        apply(0, 0, 0, 9, 9, 1, 9);
        tick();
        apply(1, 9, 'h909, 9, 9, 1, 9);
        chk("wc9_ok_a", 64'(claim_ok_a), 64'(1));
        chk("wc9_ok_b", 64'(claim_ok_b), 64'(0));
        tick();
        chk("wc9_busy_a", 64'(busy_vec_a[9]), 64'(1));
        chk("wc9_busy_b", 64'(busy_vec_b[9]), 64'(0));
        apply(0, 0, 0, 9, 9, 0, 0);
        chk("wc9_rd_a", 64'(rd_data_a[31:0]), 64'h909);
        tick();

        apply(1, 12, 'hC0C, 4, 12, 1, 4);
        tick();
        chk("par_busy4", 64'(busy_vec_a[4]), 64'(1));
        apply(0, 0, 0, 12, 4, 0, 0);
        chk("par_rd12", 64'(rd_data_a[31:0]), 64'hC0C);
        tick();

        apply(0, 0, 0, 0, 0, 1, 0);
        chk("claim0_ok_a", 64'(claim_ok_a), 64'(1));
        tick();
        chk("claim0_busy_a", 64'(busy_vec_a[0]), 64'(0));
        chk("claim0_busy_b", 64'(busy_vec_b[0]), 64'(1));
        apply(0, 0, 0, 0, 0, 1, 0);
        chk("claim0_again_b", 64'(claim_ok_b), 64'(0));
        tick();

        repeat (400) begin
            apply(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the 32x32 MIPS register bank. It adds a configurable number of read ports, same-cycle write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard. Sits between decode (claims destination registers and reads operands) and writeback (writes results and releases registers) in the pipelined mips32 core.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth NREG = 2**ADDR_W
NREAD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
BYPASS, 1, 1 = same-cycle writeback is forwarded to read ports and busy status

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears all registers and busy bits
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback register index
wr_data  in  DATA_W  writeback data
rd_addr  in  NREAD*ADDR_W  packed read indices; port k = bits [k*ADDR_W +: ADDR_W]
rd_data  out  NREAD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
rd_busy  out  NREAD  per-port busy flag of the addressed register
claim_en  in  1  decode requests ownership of claim_addr
claim_addr  in  ADDR_W  register to mark busy
claim_ok  out  1  combinational grant for this cycle's claim
busy_vec  out  2**ADDR_W  registered scoreboard, bit i = register i busy

Behaviour:
- Reset (async, any time, including mid-operation): every register = 0 and busy_vec = 0 immediately. rd_data then shows 0 and rd_busy = 0. claim_ok is combinational and follows its inputs.
- Reads are combinational, 0-cycle latency. All ports are independent, and any ports may address the same register.
- ZERO_REG=1: a read of index 0 returns 0 and rd_busy=0. Writes to 0 are dropped. A claim of 0 gets claim_ok=1 and changes no state.
- Write: at posedge with wr_en=1 (and wr_addr!=0 when ZERO_REG), reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. This also applies if the register was not busy.
- Bypass (BYPASS=1): if wr_en=1, rd_addr_k==wr_addr and the write is not dropped, then rd_data_k = wr_data and rd_busy_k = 0 in the same cycle. BYPASS=0: the read returns the old value and the old busy bit.
- eff_busy(a) = busy[a] & ~(BYPASS & wr_en & wr_addr==a & write not dropped).
- claim_ok = claim_en & ~eff_busy(claim_addr). It is forced to 1 for index 0 when ZERO_REG and claim_en=1, and is 0 when claim_en=0.
- Claim: at posedge with claim_ok=1 (non-zero index), busy[claim_addr] <= 1. If claim_ok=0, no state change occurs, and the requester retries.
- Simultaneous write and claim to the same register:
  - The data is written.
  - With BYPASS=1, the claim is granted and the busy bit ends at 1 (claim wins).
  - With BYPASS=0 and the register busy, the claim is refused and the busy bit ends at 0.
  - With BYPASS=0 and the register not busy, the claim is granted and the busy bit ends at 1.
- A write and a claim to different registers both take effect in the same cycle.
- No X is ever driven on outputs after reset. Out-of-range NREAD is a synthesis error (static assertion).

Test Plan:
- Async reset: preload reg5=0x55 with busy5=1, then assert reset between clock edges. Without waiting for an edge: rd_data=0, busy_vec=0.
- Multi-port write/read: write reg i = i*10 for i=1..31, then read (i, i+1) on two ports. Required: port0=i*10, port1=(i+1)*10 and rd_busy=0 on both. Read of reg0=0 after a write of 0xDEAD to 0.
- Bypass: with reg7=70, present wr_en=1, wr_addr=7, wr_data=0x1234 and rd_addr port1=7 in the same cycle. Required: rd_data port1=0x1234 before the edge, and reg7=0x1234 after. With BYPASS=0 the port shows 70 before the edge.
- Scoreboard: claim reg3 gives claim_ok=1 and busy_vec[3]=1 next cycle. A second claim of 3 gives claim_ok=0 and no change. A write to 3 of 0x99 clears busy_vec[3] and rd_data=0x99.
- Simultaneous write and claim to reg9 (busy), BYPASS=1: claim_ok=1, reg9 written, busy_vec[9] stays 1. A parallel claim of reg4 plus a write of reg12 both take effect.
- Zero register: a claim of 0 gives claim_ok=1 and busy_vec[0] stays 0. With ZERO_REG=0, reg0 is writable and claimable like any other register.
